// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, instruction register and the IF/HOLD/HALT
// sequencer that interlocks instruction latching with PC commit.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 128
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        IRWre,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] Immediate,
  input  logic [25:0] JumpAddr,
  input  logic [31:0] RegData,
  input  logic        Halt,
  input  logic [31:0] IDataIn,
  output logic [31:0] IAddr,
  output logic        RW,
  output logic [31:0] IR,
  output logic [31:0] PC4,
  output logic        Fetched,
  output logic        Halted,
  output logic        AddrErr
);

  typedef enum logic [1:0] {
    ST_IF   = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Highest PC from which a full word can still be read out of the store.
  localparam logic [31:0] ADDR_LIMIT = 32'(IMEM_BYTES - 4);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        fetched_q, fetched_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] pc4;
  logic [31:0] next_pc;

  // Word alignment drops these bits; tying them off keeps the intent explicit.
  logic unused_bits;
  assign unused_bits = ^{RegData[1:0], Immediate[31:30]};

  assign pc4 = pc_q + 32'd4;

  always_comb begin
    next_pc = pc4;
    unique case (PCSrc)
      2'b00: next_pc = pc4;
      2'b01: next_pc = pc4 + {Immediate[29:0], 2'b00};
      2'b10: next_pc = {RegData[31:2], 2'b00};
      2'b11: next_pc = {pc4[31:28], JumpAddr, 2'b00};
      default: next_pc = pc4;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    fetched_d  = 1'b0;
    addr_err_d = addr_err_q;
    unique case (state_q)
      ST_IF: begin
        if (pc_q > ADDR_LIMIT) addr_err_d = 1'b1;
        if (IRWre) begin
          ir_d      = IDataIn;
          fetched_d = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (PCWre) begin
          if (Halt) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_IF;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IF;
      pc_q       <= RESET_PC;
      ir_q       <= 32'd0;
      fetched_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      fetched_q  <= fetched_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign IAddr   = pc_q;
  assign PC4     = pc4;
  assign IR      = ir_q;
  assign RW      = (state_q != ST_HALT);
  assign Halted  = (state_q == ST_HALT);
  assign Fetched = fetched_q;
  assign AddrErr = addr_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a transaction-level model of fetch/commit/halt.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          IMEM_BYTES = 128;
  localparam logic [31:0] LIMIT      = 32'(IMEM_BYTES - 4);

  logic        CLK, Reset, IRWre, PCWre, Halt;
  logic [1:0]  PCSrc;
  logic [31:0] Immediate, RegData, IDataIn;
  logic [25:0] JumpAddr;
  logic [31:0] IAddr, IR, PC4;
  logic        RW, Fetched, Halted, AddrErr;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: PC, IR, and whether an instruction is waiting for its PC commit.
  logic [31:0] m_pc, m_ir;
  logic        m_have_ir, m_halted, m_fetched, m_err;

  fetch_unit #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
    .CLK(CLK), .Reset(Reset), .IRWre(IRWre), .PCWre(PCWre), .PCSrc(PCSrc),
    .Immediate(Immediate), .JumpAddr(JumpAddr), .RegData(RegData), .Halt(Halt),
    .IDataIn(IDataIn), .IAddr(IAddr), .RW(RW), .IR(IR), .PC4(PC4),
    .Fetched(Fetched), .Halted(Halted), .AddrErr(AddrErr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_ir = 32'd0;
    m_have_ir = 1'b0; m_halted = 1'b0; m_fetched = 1'b0; m_err = 1'b0;
  endtask

  // One rising edge as seen by the model, using the inputs currently applied.
  task automatic model_edge();
    logic [31:0] target;
    m_fetched = 1'b0;
    if (m_halted) return;
    if (!m_have_ir) begin
      if (m_pc > LIMIT) m_err = 1'b1;
      if (IRWre) begin
        m_ir = IDataIn; m_fetched = 1'b1; m_have_ir = 1'b1;
      end
    end else if (PCWre) begin
      if (Halt) m_halted = 1'b1;
      else begin
        case (PCSrc)
          2'd0:    target = m_pc + 32'd4;
          2'd1:    target = m_pc + 32'd4 + Immediate * 32'd4;
          2'd2:    target = RegData & ~32'd3;
          default: target = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, JumpAddr} * 32'd4);
        endcase
        m_pc = target; m_have_ir = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_iaddr"},   IAddr,          m_pc);
    check({tag, "_pc4"},     PC4,            m_pc + 32'd4);
    check({tag, "_ir"},      IR,             m_ir);
    check({tag, "_rw"},      32'(RW),        32'(!m_halted));
    check({tag, "_fetched"}, 32'(Fetched),   32'(m_fetched));
    check({tag, "_halted"},  32'(Halted),    32'(m_halted));
    check({tag, "_addrerr"}, 32'(AddrErr),   32'(m_err));
  endtask

  // Inputs are applied at the falling edge; outputs are compared at the next falling edge.
  task automatic tick(input string tag);
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    IRWre = 1'b0; PCWre = 1'b0; Halt = 1'b0; PCSrc = 2'd0;
    Immediate = 32'd0; JumpAddr = 26'd0; RegData = 32'd0;
  endtask

  // Pulse reset between clock edges and confirm the clear happens without an edge.
  task automatic async_reset(input string tag);
    Reset = 1'b0;
    #2;
    model_reset();
    compare_all(tag);
    Reset = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] word);
    IRWre = 1'b1; IDataIn = word;
    tick("fetch");
    IRWre = 1'b0;
  endtask

  task automatic commit(input logic [1:0] src, input string tag);
    PCWre = 1'b1; PCSrc = src;
    tick(tag);
    PCWre = 1'b0;
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    fetch($urandom);
    RegData = addr;
    commit(2'd2, "goto");
  endtask

  initial begin
    Reset = 1'b0; IDataIn = 32'd0;
    idle_inputs();
    model_reset();
    #2;
    compare_all("reset");
    @(negedge CLK);
    Reset = 1'b1;

    // First fetch after reset comes from RESET_PC with a one-cycle Fetched pulse.
    fetch(32'h2001_0005);
    check("req38_ir", IR, 32'h2001_0005);
    check("req38_fetched", 32'(Fetched), 32'd1);
    check("req38_iaddr", IAddr, 32'd0);
    tick("hold_idle");
    check("req38_fetched_drop", 32'(Fetched), 32'd0);

    goto_pc(32'd8);
    fetch(32'h1111_0000);
    commit(2'd0, "seq");
    check("seq_iaddr", IAddr, 32'd12);
    check("seq_pc4", PC4, 32'd16);

    goto_pc(32'd16);
    fetch(32'h2222_0000);
    Immediate = 32'hFFFF_FFFE;
    commit(2'd1, "branch");
    check("branch_iaddr", IAddr, 32'd12);

    goto_pc(32'd4);
    fetch(32'h3333_0000);
    JumpAddr = 26'h000_0010;
    commit(2'd3, "jump");
    check("jump_iaddr", IAddr, 32'h40);

    fetch(32'h4444_0000);
    RegData = 32'h0000_0023;
    commit(2'd2, "jr");
    check("jr_iaddr", IAddr, 32'h20);
    PCWre = 1'b1; PCSrc = 2'd0;
    tick("pcwre_in_if");
    PCWre = 1'b0;
    check("pcwre_in_if_iaddr", IAddr, 32'h20);

    goto_pc(32'd124);
    tick("edge124");
    check("addr124_err", 32'(AddrErr), 32'd0);
    fetch(32'h5555_AAAA);
    RegData = 32'd128;
    commit(2'd2, "to128");
    tick("edge128");
    check("addr128_err", 32'(AddrErr), 32'd1);
    fetch(32'h6666_BBBB);
    check("addr128_ir", IR, 32'h6666_BBBB);
    RegData = 32'd0;
    commit(2'd2, "back0");
    check("addr_err_sticky", 32'(AddrErr), 32'd1);
    async_reset("err_clear");
    check("err_cleared", 32'(AddrErr), 32'd0);

    goto_pc(32'hFFFF_FFFC);
    check("wrap_pc4", PC4, 32'd0);
    fetch(32'h7777_0000);
    commit(2'd0, "wrap_seq");
    check("wrap_iaddr", IAddr, 32'd0);
    async_reset("rst_wrap");

    // Halt: terminal until reset, PC and IR frozen under any strobe activity.
    goto_pc(32'd20);
    fetch(32'h8888_0000);
    Halt = 1'b1;
    commit(2'd0, "halt");
    check("halt_halted", 32'(Halted), 32'd1);
    check("halt_rw", 32'(RW), 32'd0);
    for (int i = 0; i < 10; i++) begin
      IRWre = 1'($urandom_range(0, 1)); PCWre = 1'($urandom_range(0, 1));
      Halt = 1'($urandom_range(0, 1)); IDataIn = $urandom;
      tick("halted_loop");
      check("halt_iaddr_frozen", IAddr, 32'd20);
    end
    idle_inputs();
    async_reset("rst_halt");

    // Reset while an instruction is held aborts it with no PC/IR residue.
    fetch(32'h9999_0000);
    RegData = 32'd40;
    PCWre = 1'b1; PCSrc = 2'd2;
    async_reset("rst_hold");
    check("rst_hold_pc", IAddr, RESET_PC);
    PCWre = 1'b0;
    fetch(32'hAAAA_0000);
    check("after_rst_fetch_addr", IAddr, RESET_PC);

    for (int i = 0; i < 600; i++) begin
      IRWre     = 1'($urandom_range(0, 1));
      PCWre     = 1'($urandom_range(0, 1));
      Halt      = ($urandom_range(0, 15) == 0);
      PCSrc     = 2'($urandom_range(0, 3));
      Immediate = 32'($urandom_range(0, 16)) - 32'd8;
      JumpAddr  = 26'($urandom_range(0, 40));
      RegData   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 160));
      IDataIn   = $urandom;
      if ($urandom_range(0, 29) == 0) async_reset("rand_rst");
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
